// File: rtl/fft_reader_pkg.sv
// Shared types and sizing for the FFT peak reader.
// FFT_MAG_APPROX_EN selects the multiplier-free magnitude, which also narrows MWIDTH.
package fft_reader_pkg;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    // S1 abs/products, S2 magnitude, S3 compare/update
    localparam int unsigned PIPE_DEPTH = 3;

    function automatic int unsigned mag_width(input int unsigned iwidth);
`ifdef FFT_MAG_APPROX_EN
        return iwidth;
`else
        return 2 * iwidth;
`endif
    endfunction

endpackage

// File: rtl/fft_mag.sv
// Two-stage magnitude pipeline: exact re^2+im^2, or max+min/2 when FFT_MAG_APPROX_EN is defined.
module fft_mag
    import fft_reader_pkg::*;
#(
    parameter int unsigned IWIDTH = 22,
    parameter int unsigned MWIDTH = mag_width(IWIDTH)
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_ce,
    input  logic                  i_valid,
    input  logic [2*IWIDTH-1:0]   i_result,
    output logic                  o_valid,
    output logic [MWIDTH-1:0]     o_mag
);

    logic [IWIDTH-1:0] re, im, re_abs, im_abs;
    logic              s1_valid;

    // |x| as IWIDTH unsigned bits, so the most-negative input maps to 2^(IWIDTH-1) exactly
    always_comb begin
        re     = i_result[2*IWIDTH-1:IWIDTH];
        im     = i_result[IWIDTH-1:0];
        re_abs = re[IWIDTH-1] ? -re : re;
        im_abs = im[IWIDTH-1] ? -im : im;
    end

`ifdef FFT_MAG_APPROX_EN
    logic [IWIDTH-1:0] re_q, im_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            re_q  <= '0;
            im_q  <= '0;
            o_mag <= '0;
        end else if (i_ce) begin
            re_q  <= re_abs;
            im_q  <= im_abs;
            o_mag <= (re_q >= im_q) ? re_q + (im_q >> 1) : im_q + (re_q >> 1);
        end
    end
`else
    logic [MWIDTH-1:0] re_sq, im_sq;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            re_sq <= '0;
            im_sq <= '0;
            o_mag <= '0;
        end else if (i_ce) begin
            re_sq <= MWIDTH'(re_abs) * MWIDTH'(re_abs);
            im_sq <= MWIDTH'(im_abs) * MWIDTH'(im_abs);
            o_mag <= re_sq + im_sq;
        end
    end
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s1_valid <= 1'b0;
            o_valid  <= 1'b0;
        end else if (i_ce) begin
            s1_valid <= i_valid;
            o_valid  <= s1_valid;
        end
    end

endmodule

// File: rtl/fft_peak_reader.sv
// Per-frame peak search over a bin window of the streaming FFT output, with a valid/ack report.
// FFT_MAG_APPROX_EN switches the magnitude to the max+min/2 approximation (MWIDTH = IWIDTH).
module fft_peak_reader
    import fft_reader_pkg::*;
#(
    parameter int unsigned IWIDTH  = 22,
    parameter int unsigned LGSIZE  = 11,
    parameter int unsigned MIN_BIN = 1,
    parameter int unsigned MAX_BIN = 1023,
    localparam int unsigned MWIDTH = mag_width(IWIDTH)
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_ce,
    input  logic                  i_sync,
    input  logic [2*IWIDTH-1:0]   i_result,
    output logic                  o_valid,
    output logic [LGSIZE-1:0]     o_peak_bin,
    output logic [MWIDTH-1:0]     o_peak_mag,
    input  logic                  i_ack,
    output logic                  o_overrun
);

    localparam logic [LGSIZE-1:0] MIN_IDX = LGSIZE'(MIN_BIN);
    localparam logic [LGSIZE-1:0] MAX_IDX = LGSIZE'(MAX_BIN);

    state_t            state, state_nxt;
    logic              in_frame;
    logic [LGSIZE-1:0] cnt, cur_bin;
    logic [LGSIZE-1:0] bin_q [PIPE_DEPTH-1];
    logic [LGSIZE-1:0] s2_bin;
    logic              mag_valid;
    logic [MWIDTH-1:0] mag;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (i_ce && i_sync) state_nxt = RUN;
    end

    // A sync that cuts a frame short restarts at bin 0; the partial frame never reaches
    // bin N-1 in S3, so it produces no report without any explicit discard logic.
    assign in_frame = (state == RUN) || i_sync;
    assign cur_bin  = i_sync ? '0 : cnt + LGSIZE'(1);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt <= '0;
            for (int unsigned i = 0; i < PIPE_DEPTH - 1; i++) bin_q[i] <= '0;
        end else if (i_ce) begin
            if (in_frame) cnt <= cur_bin;
            bin_q[0] <= cur_bin;
            for (int unsigned i = 1; i < PIPE_DEPTH - 1; i++) bin_q[i] <= bin_q[i-1];
        end
    end

    assign s2_bin = bin_q[PIPE_DEPTH-2];

    fft_mag #(
        .IWIDTH (IWIDTH),
        .MWIDTH (MWIDTH)
    ) u_mag (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_ce      (i_ce),
        .i_valid   (in_frame),
        .i_result  (i_result),
        .o_valid   (mag_valid),
        .o_mag     (mag)
    );

    logic [LGSIZE-1:0] max_bin, base_bin, nxt_bin;
    logic [MWIDTH-1:0] max_mag, base_mag, nxt_mag;
    logic              s3_fire, report_load, take;

    always_comb begin
        s3_fire     = i_ce && mag_valid;
        report_load = s3_fire && (s2_bin == '1);
        base_bin    = (s2_bin == '0) ? MIN_IDX : max_bin;
        base_mag    = (s2_bin == '0) ? '0 : max_mag;
        take        = (s2_bin >= MIN_IDX) && (s2_bin <= MAX_IDX) && (mag > base_mag);
        nxt_bin     = take ? s2_bin : base_bin;
        nxt_mag     = take ? mag : base_mag;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            max_bin <= '0;
            max_mag <= '0;
        end else if (s3_fire) begin
            max_bin <= nxt_bin;
            max_mag <= nxt_mag;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_valid    <= 1'b0;
            o_peak_bin <= '0;
            o_peak_mag <= '0;
            o_overrun  <= 1'b0;
        end else begin
            o_overrun <= 1'b0;
            if (report_load) begin
                o_valid    <= 1'b1;
                o_peak_bin <= nxt_bin;
                o_peak_mag <= nxt_mag;
                o_overrun  <= o_valid && !i_ack;
            end else if (o_valid && i_ack) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fft_peak_reader.sv
// Directed bench for fft_peak_reader with N=16 and search window 1..7.
module tb_fft_peak_reader;
    import fft_reader_pkg::*;

    localparam int unsigned IW = 22;
    localparam int unsigned LG = 4;
    localparam int unsigned MW = mag_width(IW);

`ifdef FFT_MAG_APPROX_EN
    localparam logic [63:0] E_TONE = 64'd550;
    localparam logic [63:0] E_TIE  = 64'd10;
    localparam logic [63:0] E_EXT  = 64'h30_0000;
    localparam logic [63:0] E_34   = 64'd5;
    localparam logic [63:0] E_05   = 64'd5;
    localparam logic [63:0] E_20   = 64'd20;
`else
    localparam logic [63:0] E_TONE = 64'd250000;
    localparam logic [63:0] E_TIE  = 64'd100;
    localparam logic [63:0] E_EXT  = 64'h0000_0800_0000_0000;
    localparam logic [63:0] E_34   = 64'd25;
    localparam logic [63:0] E_05   = 64'd25;
    localparam logic [63:0] E_20   = 64'd400;
`endif

    logic              i_clk, i_reset_n, i_ce, i_sync, i_ack;
    logic [2*IW-1:0]   i_result;
    logic              o_valid, o_overrun;
    logic [LG-1:0]     o_peak_bin;
    logic [MW-1:0]     o_peak_mag;

    int n_cmp = 0;
    int n_err = 0;
    logic [IW-1:0] fr_re [16];
    logic [IW-1:0] fr_im [16];

    fft_peak_reader #(
        .IWIDTH  (IW),
        .LGSIZE  (LG),
        .MIN_BIN (1),
        .MAX_BIN (7)
    ) dut (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_ce       (i_ce),
        .i_sync     (i_sync),
        .i_result   (i_result),
        .o_valid    (o_valid),
        .o_peak_bin (o_peak_bin),
        .o_peak_mag (o_peak_mag),
        .i_ack      (i_ack),
        .o_overrun  (o_overrun)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_report(input string tag, input logic [63:0] bin, input logic [63:0] mag);
        check({tag, ".valid"}, 64'(o_valid), 64'd1);
        check({tag, ".bin"}, 64'(o_peak_bin), bin);
        check({tag, ".mag"}, 64'(o_peak_mag), mag);
    endtask

    // One clock: inputs driven, edge taken, then sampled 1 time unit later.
    task automatic step(input logic ce, input logic sync, input logic [IW-1:0] re,
                        input logic [IW-1:0] im, input logic ack);
        i_ce = ce; i_sync = sync; i_result = {re, im}; i_ack = ack;
        @(posedge i_clk);
        #1;
        i_ce = 1'b0; i_sync = 1'b0; i_ack = 1'b0;
    endtask

    task automatic fill(input logic [IW-1:0] re, input logic [IW-1:0] im);
        for (int i = 0; i < 16; i++) begin
            fr_re[i] = re;
            fr_im[i] = im;
        end
    endtask

    task automatic send_frame(input logic with_sync, input int last, input logic gaps);
        for (int b = 0; b <= last; b++) begin
            if (gaps) while ($urandom_range(0, 2) == 0) step(1'b0, 1'b0, '0, '0, 1'b0);
            step(1'b1, with_sync && (b == 0), fr_re[b], fr_im[b], 1'b0);
        end
    endtask

    task automatic ack_report();
        step(1'b0, 1'b0, '0, '0, 1'b1);
        check("ack.cleared", 64'(o_valid), 64'd0);
    endtask

    initial begin
        i_reset_n = 1'b0; i_ce = 1'b0; i_sync = 1'b0; i_ack = 1'b0; i_result = '0;
        #12;
        check("rst.valid", 64'(o_valid), 64'd0);
        check("rst.bin", 64'(o_peak_bin), 64'd0);
        check("rst.mag", 64'(o_peak_mag), 64'd0);
        check("rst.overrun", 64'(o_overrun), 64'd0);
        @(negedge i_clk) i_reset_n = 1'b1;
        @(posedge i_clk) #1;

        // samples before the first sync are ignored
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 22'd900, 22'd0, 1'b0);
        check("presync.valid", 64'(o_valid), 64'd0);

        // single tone and report latency, including an i_ce hold after bin 15
        fill(22'd1, 22'd1);
        fr_re[5] = 22'd300; fr_im[5] = 22'd400;
        send_frame(1'b1, 15, 1'b0);
        check("tone.lat0", 64'(o_valid), 64'd0);
        step(1'b0, 1'b0, '0, '0, 1'b0);
        check("tone.cehold", 64'(o_valid), 64'd0);
        step(1'b1, 1'b0, '0, '0, 1'b0);
        check("tone.lat1", 64'(o_valid), 64'd0);
        step(1'b1, 1'b0, '0, '0, 1'b0);
        check_report("tone", 64'd5, E_TONE);
        check("tone.overrun", 64'(o_overrun), 64'd0);
        step(1'b0, 1'b0, '0, '0, 1'b0);
        check_report("tone.hold", 64'd5, E_TONE);
        ack_report();

        // tie inside the window resolves low; DC and bin 12 are outside
        fill(22'd0, 22'd0);
        fr_re[0] = 22'd1000; fr_re[12] = 22'd1000;
        fr_re[2] = 22'd10;   fr_re[6] = 22'd10;
        send_frame(1'b1, 15, 1'b0);
        step(1'b1, 1'b0, '0, '0, 1'b0);
        step(1'b1, 1'b0, '0, '0, 1'b0);
        check_report("tie", 64'd2, E_TIE);
        ack_report();

        // most-negative components
        fill(22'd0, 22'd0);
        fr_re[3] = 22'h20_0000; fr_im[3] = 22'h20_0000;
        send_frame(1'b1, 15, 1'b0);
        step(1'b1, 1'b0, '0, '0, 1'b0);
        step(1'b1, 1'b0, '0, '0, 1'b0);
        check_report("extreme", 64'd3, E_EXT);
        ack_report();

        // all-zero window reports MIN_BIN with zero magnitude
        fill(22'd0, 22'd0);
        send_frame(1'b1, 15, 1'b0);
        step(1'b1, 1'b0, '0, '0, 1'b0);
        step(1'b1, 1'b0, '0, '0, 1'b0);
        check_report("zero", 64'd1, 64'd0);
        ack_report();

        // backpressure: second frame arrives by wrap (no sync) and overwrites
        fill(22'd0, 22'd0);
        fr_re[5] = 22'd300; fr_im[5] = 22'd400;
        send_frame(1'b1, 15, 1'b0);
        fill(22'd0, 22'd0);
        fr_re[4] = 22'd3; fr_im[4] = 22'd4;
        send_frame(1'b0, 15, 1'b0);
        check_report("bp.first", 64'd5, E_TONE);
        check("bp.first.overrun", 64'(o_overrun), 64'd0);
        step(1'b1, 1'b0, '0, '0, 1'b0);
        step(1'b1, 1'b0, '0, '0, 1'b0);
        check_report("bp.second", 64'd4, E_34);
        check("bp.second.overrun", 64'(o_overrun), 64'd1);
        step(1'b0, 1'b0, '0, '0, 1'b0);
        check("bp.overrun.pulse", 64'(o_overrun), 64'd0);
        check("bp.still.valid", 64'(o_valid), 64'd1);
        fill(22'd0, 22'd0);
        fr_im[7] = 22'd5;
        send_frame(1'b1, 15, 1'b0);
        step(1'b1, 1'b0, '0, '0, 1'b0);
        step(1'b1, 1'b0, '0, '0, 1'b1);
        check_report("bp.third", 64'd7, E_05);
        check("bp.third.overrun", 64'(o_overrun), 64'd0);
        ack_report();

        // early sync at bin 9: partial frame (with a large bin 3) leaves no trace
        fill(22'd0, 22'd0);
        fr_re[3] = 22'd1000;
        send_frame(1'b1, 8, 1'b0);
        fill(22'd0, 22'd0);
        fr_re[6] = 22'd20;
        send_frame(1'b1, 15, 1'b0);
        check("early.noreport", 64'(o_valid), 64'd0);
        step(1'b1, 1'b0, '0, '0, 1'b0);
        step(1'b1, 1'b0, '0, '0, 1'b0);
        check_report("early", 64'd6, E_20);
        ack_report();

        // random i_ce gaps give the same report as a gapless frame
        fill(22'd1, 22'd1);
        fr_re[5] = 22'd300; fr_im[5] = 22'd400;
        send_frame(1'b1, 15, 1'b1);
        for (int i = 0; i < 40 && !o_valid; i++) step(1'($urandom_range(0, 1)), 1'b0, '0, '0, 1'b0);
        check_report("gaps", 64'd5, E_TONE);

        // async reset at bin 7 with a pending report
        fill(22'd0, 22'd0);
        fr_re[4] = 22'd3; fr_im[4] = 22'd4;
        send_frame(1'b1, 7, 1'b0);
        i_reset_n = 1'b0;
        #1;
        check("midrst.valid", 64'(o_valid), 64'd0);
        check("midrst.bin", 64'(o_peak_bin), 64'd0);
        check("midrst.mag", 64'(o_peak_mag), 64'd0);
        check("midrst.overrun", 64'(o_overrun), 64'd0);
        @(negedge i_clk) i_reset_n = 1'b1;
        @(posedge i_clk) #1;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 22'd500, 22'd0, 1'b0);
        check("midrst.ignored", 64'(o_valid), 64'd0);
        send_frame(1'b1, 15, 1'b0);
        step(1'b1, 1'b0, '0, '0, 1'b0);
        step(1'b1, 1'b0, '0, '0, 1'b0);
        check_report("postrst", 64'd4, E_34);
        ack_report();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
